// File: rtl/rr_packet_arbiter_pkg.sv
// Shared types and arbitration helpers for the wormhole round-robin output-port arbiter.
package rr_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    // Helpers work on a fixed maximum width; callers zero-extend their vectors.
    localparam int unsigned MAX_REQ = 32;

    // Rotate a one-hot vector up by one position within its low n bits.
    function automatic logic [MAX_REQ-1:0] rotate_onehot(input logic [MAX_REQ-1:0] v,
                                                         input int unsigned n);
        logic [MAX_REQ-1:0] mask;
        logic               wrap;
        mask = (MAX_REQ'(1) << n) - MAX_REQ'(1);
        wrap = |(v & ~(mask >> 1));
        return ((v << 1) & mask) | MAX_REQ'(wrap);
    endfunction

    // First set request at or above the priority bit, else the lowest set request.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [MAX_REQ-1:0] pri);
        logic [MAX_REQ-1:0] hi;
        hi = req & ~(pri - MAX_REQ'(1));
        if (hi != '0)
            return hi & (-hi);
        return req & (-req);
    endfunction

endpackage

// File: rtl/rr_packet_arbiter_if.sv
// Request/grant bundle between input-port buffers, the arbiter and the crossbar mux select.
interface rr_packet_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] tail_i;
    logic               out_ready_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic               xfer_o;
    logic               busy_o;
    logic [NUM_REQ-1:0] priority_o;
    logic               timeout_o;

    modport slave (
        input  req_i, tail_i, out_ready_i,
        output gnt_o, xfer_o, busy_o, priority_o, timeout_o
    );

    modport master (
        output req_i, tail_i, out_ready_i,
        input  gnt_o, xfer_o, busy_o, priority_o, timeout_o
    );
endinterface

// File: rtl/rr_packet_arbiter_priority_reg.sv
// One-hot rotating priority register; resets to requester 0 and moves just past the winner on release.
module rr_priority_reg
    import rr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    input  logic [NUM_REQ-1:0] winner,
    output logic [NUM_REQ-1:0] priority_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            priority_q <= NUM_REQ'(1);
        else if (advance)
            priority_q <= NUM_REQ'(rotate_onehot(MAX_REQ'(winner), NUM_REQ));
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Wormhole round-robin arbiter: locks one requester head-to-tail, then rotates priority past it.
// Optional stall-timeout release is built when RR_PACKET_ARB_TIMEOUT_EN is defined.
module rr_packet_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    rr_packet_arbiter_if.slave bus
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("rr_packet_arbiter: unsupported NUM_REQ/TIMEOUT_CYCLES");
    end

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] pri_q;
    logic [NUM_REQ-1:0] pick;
    logic               busy_q;
    logic               xfer;
    logic               tail_sel;
    logic               release_arb;
    logic               timeout_hit;

    assign pick     = NUM_REQ'(rr_pick(MAX_REQ'(bus.req_i), MAX_REQ'(pri_q)));
    assign xfer     = (|(gnt_q & bus.req_i)) & bus.out_ready_i;
    assign tail_sel = |(gnt_q & bus.tail_i);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        release_arb = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_i != '0) begin
                    state_d = LOCKED;
                    gnt_d   = pick;
                end
            end
            LOCKED: begin
                if ((xfer && tail_sel) || timeout_hit) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    release_arb = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= (state_d == LOCKED);
        end
    end

    // gnt_q still holds the winner during the release cycle, so it seeds the rotation.
    rr_priority_reg #(
        .NUM_REQ (NUM_REQ)
    ) u_priority (
        .clk        (clk),
        .reset      (reset),
        .advance    (release_arb),
        .winner     (gnt_q),
        .priority_q (pri_q)
    );

`ifdef RR_PACKET_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic             timeout_q;

    // Release on the edge where the stall count would reach TIMEOUT_CYCLES.
    assign timeout_hit = (state_q == LOCKED) && !xfer &&
                         (stall_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        stall_d = stall_q + CNT_W'(1);
        if (state_q != LOCKED || xfer || timeout_hit)
            stall_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_hit;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.gnt_o      = gnt_q;
    assign bus.xfer_o     = xfer;
    assign bus.busy_o     = busy_q;
    assign bus.priority_o = pri_q;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter with a packet-level reference model checked every cycle.
module tb_rr_packet_arbiter;

    localparam int N   = 4;
    localparam int TMO = 4;
`ifdef RR_PACKET_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    rr_packet_arbiter_if #(.NUM_REQ(N)) bus ();

    rr_packet_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 when idle), priority index, stall count.
    int m_owner = -1;
    int m_pri   = 0;
    int m_stall = 0;
    bit m_tmo   = 1'b0;

    always @(posedge clk or posedge reset) begin
        logic [31:0] r, t;
        bit          found, mx;
        r = 32'(bus.req_i);
        t = 32'(bus.tail_i);
        if (reset) begin
            m_owner = -1;
            m_pri   = 0;
            m_stall = 0;
            m_tmo   = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && (((r >> ((m_pri + k) % N)) & 32'd1) != 0)) begin
                        m_owner = (m_pri + k) % N;
                        found   = 1'b1;
                    end
                end
                m_stall = 0;
            end else begin
                mx = (((r >> m_owner) & 32'd1) != 0) && bus.out_ready_i;
                if (mx && (((t >> m_owner) & 32'd1) != 0)) begin
                    m_pri   = (m_owner + 1) % N;
                    m_owner = -1;
                end else if (mx) begin
                    m_stall = 0;
                end else begin
                    m_stall++;
                    if (TMO_EN && m_stall == TMO) begin
                        m_pri   = (m_owner + 1) % N;
                        m_owner = -1;
                        m_tmo   = 1'b1;
                        m_stall = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] r;
        bit          exp_xfer;
        if (!reset) begin
            r        = 32'(bus.req_i);
            exp_xfer = (m_owner >= 0) && (((r >> m_owner) & 32'd1) != 0) && bus.out_ready_i;
            check("model_gnt", 32'(bus.gnt_o), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("model_busy", 32'(bus.busy_o), 32'(m_owner >= 0));
            check("model_priority", 32'(bus.priority_o), 32'd1 << m_pri);
            check("model_xfer", 32'(bus.xfer_o), 32'(exp_xfer));
            check("model_timeout", 32'(bus.timeout_o), 32'(m_tmo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [N-1:0] req, input logic [N-1:0] tail, input logic rdy);
        bus.req_i       = req;
        bus.tail_i      = tail;
        bus.out_ready_i = rdy;
    endtask

    task automatic do_reset();
        set_in('0, '0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seq2 [10];
        logic        rdy3 [4];
        logic        tl3  [4];
        int          n5;
        seq2 = '{32'b0001, 32'b0, 32'b0010, 32'b0, 32'b0100, 32'b0, 32'b1000, 32'b0, 32'b0001, 32'b0};
        rdy3 = '{1'b1, 1'b0, 1'b1, 1'b1};
        tl3  = '{1'b0, 1'b0, 1'b0, 1'b1};
        n5   = TMO_EN ? 3 : 5;

        // 1: reset values, first grant, tail release rotates past the winner
        do_reset();
        check("rst_gnt", 32'(bus.gnt_o), 32'b0000);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_priority", 32'(bus.priority_o), 32'b0001);
        check("rst_timeout", 32'(bus.timeout_o), 32'd0);
        set_in(4'b1010, 4'b1010, 1'b0);
        tick();
        check("t1_gnt", 32'(bus.gnt_o), 32'b0010);
        check("t1_busy", 32'(bus.busy_o), 32'd1);
        check("t1_priority", 32'(bus.priority_o), 32'b0001);
        check("t1_xfer_stalled", 32'(bus.xfer_o), 32'd0);
        bus.out_ready_i = 1'b1;
        #1;
        check("t1_xfer", 32'(bus.xfer_o), 32'd1);
        tick();
        check("t1_rel_gnt", 32'(bus.gnt_o), 32'b0000);
        check("t1_rel_priority", 32'(bus.priority_o), 32'b0100);
        check("t1_rel_busy", 32'(bus.busy_o), 32'd0);
        set_in('0, '0, 1'b0);
        tick();

        // 2: four single-flit requesters, grant order 0,1,2,3,0 with idle bubbles
        do_reset();
        set_in(4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_gnt_seq", 32'(bus.gnt_o), seq2[i]);
        end
        set_in('0, '0, 1'b0);
        tick();

        // 3: 3-flit packet on port 2 with backpressure, port 0 waits
        do_reset();
        set_in(4'b0100, 4'b0000, 1'b0);
        tick();
        check("t3_gnt_head", 32'(bus.gnt_o), 32'b0100);
        for (int i = 0; i < 4; i++) begin
            set_in(4'b0101, {1'b0, tl3[i], 1'b0, 1'b1}, rdy3[i]);
            #1;
            check("t3_gnt_hold", 32'(bus.gnt_o), 32'b0100);
            check("t3_xfer", 32'(bus.xfer_o), 32'(rdy3[i]));
            tick();
        end
        check("t3_rel_gnt", 32'(bus.gnt_o), 32'b0000);
        check("t3_rel_priority", 32'(bus.priority_o), 32'b1000);
        set_in(4'b0001, 4'b0001, 1'b1);
        tick();
        check("t3_next_gnt", 32'(bus.gnt_o), 32'b0001);
        tick();
        check("t3_final_priority", 32'(bus.priority_o), 32'b0010);
        set_in('0, '0, 1'b0);
        tick();

        // 4: asynchronous reset in the middle of a port-1 packet
        do_reset();
        set_in(4'b0001, 4'b0001, 1'b1);
        tick();
        tick();
        set_in(4'b0010, 4'b0000, 1'b1);
        tick();
        check("t4_gnt", 32'(bus.gnt_o), 32'b0010);
        check("t4_priority", 32'(bus.priority_o), 32'b0010);
        tick();
        #1 reset = 1'b1;
        #1;
        check("t4_async_gnt", 32'(bus.gnt_o), 32'b0000);
        check("t4_async_busy", 32'(bus.busy_o), 32'd0);
        check("t4_async_priority", 32'(bus.priority_o), 32'b0001);
        set_in('0, '0, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // 5: port 3 drops its request mid-packet; grant is held, nothing moves
        do_reset();
        set_in(4'b1000, 4'b0000, 1'b1);
        tick();
        check("t5_gnt", 32'(bus.gnt_o), 32'b1000);
        set_in(4'b0001, 4'b0001, 1'b1);
        for (int i = 0; i < n5; i++) begin
            #1;
            check("t5_gnt_hold", 32'(bus.gnt_o), 32'b1000);
            check("t5_xfer_off", 32'(bus.xfer_o), 32'd0);
            tick();
        end
        set_in(4'b1001, 4'b1001, 1'b1);
        #1;
        check("t5_tail_xfer", 32'(bus.xfer_o), 32'd1);
        tick();
        check("t5_rel_priority", 32'(bus.priority_o), 32'b0001);
        set_in(4'b0001, 4'b0001, 1'b1);
        tick();
        check("t5_next_gnt", 32'(bus.gnt_o), 32'b0001);
        tick();
        set_in('0, '0, 1'b0);
        tick();

`ifdef RR_PACKET_ARB_TIMEOUT_EN
        // 6: stalled port 1 is force-released after TIMEOUT_CYCLES stall cycles
        do_reset();
        set_in(4'b0010, 4'b0000, 1'b0);
        tick();
        check("t6_gnt", 32'(bus.gnt_o), 32'b0010);
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            check("t6_gnt_hold", 32'(bus.gnt_o), 32'b0010);
            check("t6_no_timeout", 32'(bus.timeout_o), 32'd0);
        end
        tick();
        check("t6_timeout", 32'(bus.timeout_o), 32'd1);
        check("t6_rel_gnt", 32'(bus.gnt_o), 32'b0000);
        check("t6_rel_priority", 32'(bus.priority_o), 32'b0100);
        set_in('0, '0, 1'b0);
        tick();
        check("t6_timeout_pulse", 32'(bus.timeout_o), 32'd0);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Wormhole output-port arbiter for a NOC router.
- Shares one output port among NUM_REQ input ports using rotating one-hot round-robin priority.
- Locks the grant to one requester from head flit to tail flit, then rotates priority past the winner.
- Sits between input-port buffers and the output crossbar mux. gnt_o drives the mux select directly.

Parameters:
- NUM_REQ, 4: number of requesting input ports (>=2).
- TIMEOUT_CYCLES, 16: stall cycles before forced release. Used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_i  in  NUM_REQ  bit i: input port i holds a valid flit for this output
- tail_i  in  NUM_REQ  bit i: port i's current flit is a tail (single-flit packet = head+tail)
- out_ready_i  in  1  downstream accepts a flit this cycle
- gnt_o  out  NUM_REQ  registered one-hot grant; all zero when idle
- xfer_o  out  1  combinational: |(gnt_o & req_i) & out_ready_i; a flit moves this cycle
- busy_o  out  1  registered: 1 while in LOCKED
- priority_o  out  NUM_REQ  registered one-hot; set bit marks the highest-priority requester
- timeout_o  out  1  one-cycle pulse on forced release (always 0 without the macro)

Behaviour:
- Reset is asynchronous and active-high. It applies immediately, mid-packet included, and sets:
  - state=IDLE, gnt_o=0, busy_o=0, timeout_o=0, stall counter=0
  - priority_o=one-hot bit 0, i.e. requester 0 is highest
- FSM states: IDLE, LOCKED.
- IDLE:
  - If req_i==0: stay in IDLE.
  - Otherwise, pick winner w = first set req_i bit, scanning circularly upward from the priority_o bit.
  - At the next edge: gnt_o=onehot(w), state=LOCKED. Request-to-grant latency is 1 cycle.
  - xfer_o is always 0 in IDLE.
- LOCKED, winner w:
  - gnt_o is held constant.
  - A transfer occurs when req_i[w] && out_ready_i.
  - Transfer with tail_i[w]=1: at the next edge, state=IDLE, gnt_o=0, priority_o=onehot((w+1) mod NUM_REQ).
  - Transfer with tail_i[w]=0: stay in LOCKED.
  - req_i[w] dropping mid-packet does not release the grant (wormhole hold). Other requesters wait.
- Back-to-back packets pay one IDLE bubble cycle. This is intentional.
- tail_i bits of non-granted requesters are ignored.
- priority_o changes only on release, never in IDLE and never on a non-tail transfer.
- Simultaneous events: when a tail transfer and new requests occur in the same cycle, the new requests are arbitrated in the following IDLE cycle against the rotated priority.
- Invariant: gnt_o is always one-hot or zero. Assertion: $onehot0(gnt_o).

Optional Feature:
- Macro: RR_PACKET_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter of width $clog2(TIMEOUT_CYCLES+1) increments on every LOCKED cycle without a transfer.
  - The counter clears on any transfer and on entry to LOCKED.
  - When the counter reaches TIMEOUT_CYCLES, release as for a tail: IDLE, gnt_o=0, priority rotates past w.
  - timeout_o=1 for exactly that one cycle (registered, coincident with the IDLE entry edge).
- Not defined:
  - No counter is built and timeout_o is tied to 0.
  - A LOCKED grant waits indefinitely.

Decomposition:
- Package rr_arb_pkg holds:
  - typedef enum logic {IDLE, LOCKED} arb_state_t
  - function rotate_onehot
  - function rr_pick: circular priority select, returns one-hot
- Sub-module rr_priority_reg: one-hot priority register with reset to bit 0 and an advance input. It loads onehot(w+1) on release.
- FSM, grant register and timeout counter live in the top module.

Test Plan:
1. Reset, then req_i=4'b1010 → next cycle gnt_o=4'b0010, busy_o=1, priority_o=4'b0001. After a tail transfer, priority_o=4'b0100 and gnt_o=0.
2. All four requesting continuously, each sending single-flit packets, out_ready_i=1 → grant order 0,1,2,3,0 with one idle cycle between grants.
3. Port 2 sends a 3-flit packet with out_ready_i toggling 1,0,1,1 and port 0 requesting throughout → gnt_o stays 4'b0100 until the tail transfer, then port 0 is granted.
4. Mid-packet on port 1, assert reset asynchronously between edges → gnt_o=0, busy_o=0 and priority_o=4'b0001 immediately, without waiting for a clock edge.
5. Port 3 locked, req_i[3] dropped for 5 cycles, port 0 requesting → gnt_o stays 4'b1000 and xfer_o=0 throughout.
6. With RR_PACKET_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4: port 1 locked, out_ready_i=0 → after 4 stall cycles timeout_o pulses for 1 cycle, gnt_o=0, priority_o=4'b0100.
